wb_sequencer: RTL and testbench

Multi-cycle control sequencer for the minimum MIPS core: the producer side of the ID stage's write port.
- Steps each instruction through IF/ID/EX/MEM/WB phases.
- Drives the BOUT phase strobes and the registered Wdata that the register file consumes.
- Issues data-memory read/write requests.
- Pulses the PC-update strobe once per retired instruction.

---
 rtl/wb_sequencer.sv | 154 +++++++++++++++
 tb/tb_wb_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer driving writeback strobes, Wdata and data-memory requests.
// Optional retired-instruction counter enabled by defining WB_SEQ_RETIRE_CNT_EN.

// state | meaning
// S_IF  | fetch; instruction becomes stable by the end of this cycle
// S_ID  | decode
// S_EX  | execute; jumps/branches and illegal opcodes finish here
// S_MEM | data-memory access, held for MEM_LAT cycles via wait_q
// S_WB  | writeback; Wdata already holds the value chosen on entry
module wb_sequencer #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [31:0]      Ins,
    input  logic [31:0]      Alu_out,
    input  logic [31:0]      Mem_rdata,
    input  logic [31:0]      Pc_plus4,
    output logic [2:0]       BOUT,
    output logic [31:0]      Wdata,
    output logic [2:0]       Phase,
    output logic             Mem_re,
    output logic             Mem_we,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [5:0] OP_R_FORM = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] wdata_q, wdata_d;

    logic [5:0] opcode;
    logic       is_alu, is_jal, is_jmp, is_lw, is_sw;
    logic [2:0] bout;
    logic       mem_re, mem_we, illegal;
    logic       unused_ins;

    assign opcode     = Ins[31:26];
    assign unused_ins = ^Ins[25:0];

    assign is_alu = (opcode == OP_R_FORM) || (opcode == OP_ADDI) || (opcode == OP_SLTI);
    assign is_jal = (opcode == OP_JAL);
    assign is_jmp = (opcode == OP_J) || (opcode == OP_BEQ);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        wdata_d = wdata_q;
        bout    = 3'b000;
        mem_re  = 1'b0;
        mem_we  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: state_d = S_EX;
            S_EX: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                    wait_d  = WAIT_INIT;
                end else if (is_alu || is_jal) begin
                    state_d = S_WB;
                    wdata_d = is_jal ? Pc_plus4 : Alu_out;
                end else begin
                    // Illegal opcodes end here without advancing the PC.
                    state_d = S_IF;
                    bout[2] = is_jmp;
                    illegal = ~is_jmp;
                end
            end
            S_MEM: begin
                mem_re = is_lw;
                mem_we = is_sw;
                if (wait_q == 4'd0) begin
                    if (is_lw) begin
                        state_d = S_WB;
                        wdata_d = Mem_rdata;
                    end else begin
                        state_d = S_IF;
                        bout[2] = is_sw;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_WB: begin
                state_d = S_IF;
                bout[0] = is_alu;
                bout[1] = is_jal || is_lw;
                bout[2] = 1'b1;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IF;
            wait_q  <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wdata_q <= wdata_d;
        end
    end

    assign BOUT    = bout;
    assign Wdata   = wdata_q;
    assign Phase   = state_q;
    assign Mem_re  = mem_re;
    assign Mem_we  = mem_we;
    assign Illegal = illegal;

`ifdef WB_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (bout[2]) retired_d = retired_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) retired_q <= '0;
        else     retired_q <= retired_d;
    end

    assign Retired = retired_q;
`else
    assign Retired = '0;
`endif

endmodule

// File: tb/tb_wb_sequencer.sv
// Scoreboard bench: each issued instruction pushes its per-cycle expected trace; monitors compare on negedge.
// Instance a uses MEM_LAT=2, instance b uses MEM_LAT=3; both use a 4-bit retired counter.
module tb_wb_sequencer;

    typedef struct {
        logic [2:0]  phase;
        logic [2:0]  bout;
        logic        re;
        logic        we;
        logic        ill;
        logic [31:0] wd;
        logic [3:0]  ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic [31:0] ins_a = 32'd0, ins_b = 32'd0;
    logic [31:0] alu = 32'd0, rdata = 32'd0, pc4 = 32'd0;

    logic [2:0]  bout_a, bout_b, phase_a, phase_b;
    logic [31:0] wdata_a, wdata_b;
    logic        re_a, re_b, we_a, we_b, ill_a, ill_b;
    logic [3:0]  ret_a, ret_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    logic [31:0] wd_a = 32'd0, wd_b = 32'd0;
    logic [3:0]  rm_a = 4'd0, rm_b = 4'd0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_sequencer #(.MEM_LAT(2), .CNT_W(4)) u_dut_a (
        .CLK(clk), .RST(rst_a), .Ins(ins_a), .Alu_out(alu), .Mem_rdata(rdata),
        .Pc_plus4(pc4), .BOUT(bout_a), .Wdata(wdata_a), .Phase(phase_a),
        .Mem_re(re_a), .Mem_we(we_a), .Illegal(ill_a), .Retired(ret_a)
    );

    wb_sequencer #(.MEM_LAT(3), .CNT_W(4)) u_dut_b (
        .CLK(clk), .RST(rst_b), .Ins(ins_b), .Alu_out(alu), .Mem_rdata(rdata),
        .Pc_plus4(pc4), .BOUT(bout_b), .Wdata(wdata_b), .Phase(phase_b),
        .Mem_re(re_b), .Mem_we(we_b), .Illegal(ill_b), .Retired(ret_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] ph, input logic [2:0] b,
                                input logic re, input logic we, input logic ill,
                                input logic [31:0] wd);
        exp_t e;
        e.phase = ph; e.bout = b; e.re = re; e.we = we; e.ill = ill; e.wd = wd; e.ret = 4'd0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            chk("a.phase",   32'(phase_a), 32'(ea.phase));
            chk("a.bout",    32'(bout_a),  32'(ea.bout));
            chk("a.mem_re",  32'(re_a),    32'(ea.re));
            chk("a.mem_we",  32'(we_a),    32'(ea.we));
            chk("a.illegal", 32'(ill_a),   32'(ea.ill));
            chk("a.wdata",   wdata_a,      ea.wd);
            chk("a.retired", 32'(ret_a),   32'(ea.ret));
        end
    end

    always @(negedge clk) begin
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            chk("b.phase",   32'(phase_b), 32'(eb.phase));
            chk("b.bout",    32'(bout_b),  32'(eb.bout));
            chk("b.mem_re",  32'(re_b),    32'(eb.re));
            chk("b.mem_we",  32'(we_b),    32'(eb.we));
            chk("b.illegal", 32'(ill_b),   32'(eb.ill));
            chk("b.wdata",   wdata_b,      eb.wd);
            chk("b.retired", 32'(ret_b),   32'(eb.ret));
        end
    end

    // Called just after a clock edge with the selected DUT sitting in IF.
    // abort_at >= 0 asserts reset during that cycle index of the trace.
    task automatic issue(input int sel, input logic [31:0] ins, input logic [31:0] alu_v,
                         input logic [31:0] pc4_v, input logic [31:0] rd_v, input int abort_at);
        exp_t        tr[$];
        int          lat, last_mem, n;
        logic [5:0]  op;
        logic [31:0] wd;
        logic [3:0]  ret;
        lat      = (sel == 0) ? 2 : 3;
        op       = ins[31:26];
        wd       = (sel == 0) ? wd_a : wd_b;
        ret      = (sel == 0) ? rm_a : rm_b;
        last_mem = -1;
        tr.push_back(mk(3'd0, 3'b000, 1'b0, 1'b0, 1'b0, wd));
        tr.push_back(mk(3'd1, 3'b000, 1'b0, 1'b0, 1'b0, wd));
        case (op)
            6'h00, 6'h08, 6'h0A: begin
                tr.push_back(mk(3'd2, 3'b000, 1'b0, 1'b0, 1'b0, wd));
                wd = alu_v;
                tr.push_back(mk(3'd4, 3'b101, 1'b0, 1'b0, 1'b0, wd));
            end
            6'h03: begin
                tr.push_back(mk(3'd2, 3'b000, 1'b0, 1'b0, 1'b0, wd));
                wd = pc4_v;
                tr.push_back(mk(3'd4, 3'b110, 1'b0, 1'b0, 1'b0, wd));
            end
            6'h02, 6'h04: tr.push_back(mk(3'd2, 3'b100, 1'b0, 1'b0, 1'b0, wd));
            6'h23: begin
                tr.push_back(mk(3'd2, 3'b000, 1'b0, 1'b0, 1'b0, wd));
                for (int k = 0; k < lat; k++) tr.push_back(mk(3'd3, 3'b000, 1'b1, 1'b0, 1'b0, wd));
                last_mem = 2 + lat;
                wd = rd_v;
                tr.push_back(mk(3'd4, 3'b110, 1'b0, 1'b0, 1'b0, wd));
            end
            6'h2B: begin
                tr.push_back(mk(3'd2, 3'b000, 1'b0, 1'b0, 1'b0, wd));
                for (int k = 0; k < lat; k++)
                    tr.push_back(mk(3'd3, (k == lat - 1) ? 3'b100 : 3'b000, 1'b0, 1'b1, 1'b0, wd));
            end
            default: tr.push_back(mk(3'd2, 3'b000, 1'b0, 1'b0, 1'b1, wd));
        endcase
        for (int k = 0; k < tr.size(); k++) begin
            tr[k].ret = ret;
`ifdef WB_SEQ_RETIRE_CNT_EN
            if (tr[k].bout[2]) ret = ret + 4'd1;
`endif
        end
        if (abort_at >= 0) begin
            while (tr.size() > abort_at + 1) void'(tr.pop_back());
            wd  = 32'd0;
            ret = 4'd0;
        end
        foreach (tr[k]) begin
            if (sel == 0) q_a.push_back(tr[k]);
            else          q_b.push_back(tr[k]);
        end
        if (sel == 0) begin wd_a = wd; rm_a = ret; ins_a = ins; end
        else          begin wd_b = wd; rm_b = ret; ins_b = ins; end
        n   = tr.size();
        pc4 = pc4_v;
        for (int i = 0; i < n; i++) begin
            // Alu_out and Mem_rdata carry junk outside the cycle where they are meant to be sampled.
            alu   = (i == 2) ? alu_v : (32'hBAD0_0000 + 32'(i));
            rdata = (i == last_mem) ? rd_v : (32'h5A5A_0000 + 32'(i));
            if (i == abort_at) begin
                if (sel == 0) rst_a = 1'b1;
                else          rst_b = 1'b1;
            end
            @(posedge clk);
            #1;
            if (sel == 0) rst_a = 1'b0;
            else          rst_b = 1'b0;
        end
    endtask

    task automatic idle_chk(input int sel);
        exp_t e;
        e     = mk(3'd0, 3'b000, 1'b0, 1'b0, 1'b0, (sel == 0) ? wd_a : wd_b);
        e.ret = (sel == 0) ? rm_a : rm_b;
        if (sel == 0) q_a.push_back(e);
        else          q_b.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;

        issue(0, {6'h08, 26'h0}, 32'h0000_0007, 32'h0000_0010, 32'h0, -1);
        issue(0, {6'h23, 26'h0}, 32'h0000_0100, 32'h0000_0014, 32'hDEAD_BEEF, -1);
        issue(0, {6'h03, 26'h0}, 32'h0000_0200, 32'h0000_0044, 32'h0, -1);
        issue(0, {6'h3F, 26'h0}, 32'h0000_0300, 32'h0000_0048, 32'h0, -1);
        issue(0, {6'h02, 26'h0}, 32'h0000_0400, 32'h0000_004C, 32'h0, -1);
        issue(0, {6'h04, 26'h0}, 32'h0000_0500, 32'h0000_0050, 32'h0, -1);
        issue(0, {6'h0A, 26'h0}, 32'h0000_0001, 32'h0000_0054, 32'h0, -1);
        issue(0, {6'h00, 26'h0}, 32'h1234_5678, 32'h0000_0058, 32'h0, -1);
        issue(0, {6'h2B, 26'h0}, 32'h0000_0600, 32'h0000_005C, 32'h0, -1);
        issue(0, {6'h03, 26'h0}, 32'h0000_0700, 32'h0000_0044, 32'h0, -1);
        issue(0, {6'h23, 26'h0}, 32'h0000_0800, 32'h0000_0060, 32'h1111_2222, 4);
        for (int i = 0; i < 17; i++)
            issue(0, {6'h08, 26'h0}, 32'h0000_1000 + 32'(i), 32'h0000_0064, 32'h0, -1);
        idle_chk(0);

        rst_b = 1'b0;
        issue(1, {6'h23, 26'h0}, 32'h0000_0900, 32'h0000_0070, 32'hCAFE_F00D, -1);
        issue(1, {6'h2B, 26'h0}, 32'h0000_0A00, 32'h0000_0074, 32'h0, -1);
        issue(1, {6'h02, 26'h0}, 32'h0000_0B00, 32'h0000_0078, 32'h0, -1);
        idle_chk(1);

        repeat (2) @(posedge clk);
        chk("q_a.drained", 32'(q_a.size()), 32'd0);
        chk("q_b.drained", 32'(q_b.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
